// File: rtl/rv_decode.sv
// rv_decode: RV32I(+M) instruction decode stage with output register plus skid register.
// Latency: 1 cycle from accepted i_valid to o_valid; a stalled OR parks one more word in SK.
// Backpressure: o_ready is registered and equals !SK.valid; i_stall holds o_* stable.
//
// Ports:
//   i_clk, i_reset (sync, active-high), i_flush (kill held instructions)
//   i_valid/o_ready/i_pc/i_instruction : fetch-side handshake
//   o_valid/i_stall + o_pc/o_class/o_funct3/o_alt/o_rs1/o_rs2/o_rd/o_rd_we/o_imm : decoded output
// Configuration: define EXTENSION_M_EN to decode OP funct7=0000001 as MULDIV (class 11);
//   otherwise that encoding is ILLEGAL (class 15).
module rv_decode (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instruction,
  output logic        o_ready,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [3:0]  o_class,
  output logic [2:0]  o_funct3,
  output logic        o_alt,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_rd_we,
  output logic [31:0] o_imm
);

  localparam logic [3:0] C_LUI     = 4'd0;
  localparam logic [3:0] C_AUIPC   = 4'd1;
  localparam logic [3:0] C_JAL     = 4'd2;
  localparam logic [3:0] C_JALR    = 4'd3;
  localparam logic [3:0] C_BRANCH  = 4'd4;
  localparam logic [3:0] C_LOAD    = 4'd5;
  localparam logic [3:0] C_STORE   = 4'd6;
  localparam logic [3:0] C_OP_IMM  = 4'd7;
  localparam logic [3:0] C_OP      = 4'd8;
  localparam logic [3:0] C_FENCE   = 4'd9;
  localparam logic [3:0] C_SYSTEM  = 4'd10;
`ifdef EXTENSION_M_EN
  localparam logic [3:0] C_MULDIV  = 4'd11;
`endif
  localparam logic [3:0] C_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
  } dec_t;

  // Decoded view of the word fetch is presenting this cycle.
  logic [31:0] w_ins;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_ill;
  logic [3:0]  w_cls;
  logic [31:0] w_imm;
  logic        w_alt;
  dec_t        w_dec;

  assign w_ins   = i_instruction;
  assign w_f3    = w_ins[14:12];
  assign w_f7    = w_ins[31:25];
  assign w_imm_i = {{21{w_ins[31]}}, w_ins[30:20]};
  assign w_imm_s = {{21{w_ins[31]}}, w_ins[30:25], w_ins[11:7]};
  assign w_imm_b = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {w_ins[31:12], 12'b0};
  assign w_imm_j = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  always_comb begin
    w_ill = 1'b0;
    w_cls = C_ILLEGAL;
    w_imm = 32'd0;
    w_alt = 1'b0;
    // Every valid opcode ends in 2'b11, so compressed encodings fall to default.
    case (w_ins[6:0])
      7'b0110111: begin w_cls = C_LUI;    w_imm = w_imm_u; end
      7'b0010111: begin w_cls = C_AUIPC;  w_imm = w_imm_u; end
      7'b1101111: begin w_cls = C_JAL;    w_imm = w_imm_j; end
      7'b1100111: begin w_cls = C_JALR;   w_imm = w_imm_i; w_ill = (w_f3 != 3'd0); end
      7'b1100011: begin
        w_cls = C_BRANCH; w_imm = w_imm_b;
        w_ill = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      7'b0000011: begin
        w_cls = C_LOAD; w_imm = w_imm_i;
        w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      7'b0100011: begin w_cls = C_STORE;  w_imm = w_imm_s; w_ill = (w_f3 > 3'd2); end
      7'b0010011: begin
        w_cls = C_OP_IMM; w_imm = w_imm_i;
        if (w_f3 == 3'd1) begin
          w_alt = w_ins[30];
          w_ill = (w_f7 != 7'b0000000);
        end else if (w_f3 == 3'd5) begin
          w_alt = w_ins[30];
          w_ill = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
        end
      end
      7'b0110011: begin
        w_cls = C_OP;
        case (w_f7)
          7'b0000000: w_alt = 1'b0;
          7'b0100000: begin w_alt = 1'b1; w_ill = (w_f3 != 3'd0) && (w_f3 != 3'd5); end
`ifdef EXTENSION_M_EN
          7'b0000001: w_cls = C_MULDIV;
`endif
          default:    w_ill = 1'b1;
        endcase
      end
      7'b0001111: begin w_cls = C_FENCE;  w_imm = w_imm_i; end
      7'b1110011: begin w_cls = C_SYSTEM; w_imm = w_imm_i; end
      default:    w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_cls = C_ILLEGAL;
      w_imm = 32'd0;
      w_alt = 1'b0;
    end

    w_dec        = '0;
    w_dec.pc     = i_pc;
    w_dec.cls    = w_cls;
    w_dec.funct3 = w_f3;
    w_dec.alt    = w_alt;
    w_dec.rs1    = w_ins[19:15];
    w_dec.rs2    = w_ins[24:20];
    w_dec.rd     = w_ins[11:7];
    w_dec.imm    = w_imm;
    w_dec.rd_we  = !((w_cls == C_ILLEGAL) || (w_cls == C_BRANCH) || (w_cls == C_STORE) ||
                     (w_cls == C_FENCE) || (w_ins[11:7] == 5'd0));
  end

  // Output register (OR) and skid register (SK).
  dec_t r_or, r_sk;
  logic r_or_vld, r_sk_vld, r_ready;

  logic w_acc, w_or_free;
  assign w_acc     = i_valid && r_ready;
  assign w_or_free = !r_or_vld || !i_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_or_vld <= 1'b0;
      r_sk_vld <= 1'b0;
      r_ready  <= 1'b1;
      r_or     <= '0;
      r_or.cls <= C_ILLEGAL;
      r_sk     <= '0;
    end else if (i_flush) begin
      r_or_vld <= 1'b0;
      r_sk_vld <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_or_free) begin
        // SK is older than anything fetch presents, so it always refills OR first.
        // o_ready is low whenever SK is full, so no accept can coincide with this move.
        if (r_sk_vld) begin
          r_or     <= r_sk;
          r_or_vld <= 1'b1;
          r_sk_vld <= 1'b0;
        end else if (w_acc) begin
          r_or     <= w_dec;
          r_or_vld <= 1'b1;
        end else begin
          r_or_vld <= 1'b0;
        end
        r_ready <= 1'b1;
      end else begin
        if (w_acc) begin
          r_sk     <= w_dec;
          r_sk_vld <= 1'b1;
        end
        r_ready <= !(r_sk_vld || w_acc);
      end
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_or_vld;
  assign o_pc     = r_or.pc;
  assign o_class  = r_or.cls;
  assign o_funct3 = r_or.funct3;
  assign o_alt    = r_or.alt;
  assign o_rs1    = r_or.rs1;
  assign o_rs2    = r_or.rs2;
  assign o_rd     = r_or.rd;
  assign o_rd_we  = r_or.rd_we;
  assign o_imm    = r_or.imm;

endmodule

// File: tb/tb_rv_decode.sv
// tb_rv_decode: table vectors, hand-written stall/flush/reset sequences and random traffic,
// all checked against a queue-based occupancy model and an arithmetic decode reference.
module tb_rv_decode;

  logic        i_clk = 1'b0;
  logic        i_reset, i_flush, i_valid, i_stall;
  logic [31:0] i_pc, i_instruction;
  logic        o_ready, o_valid, o_alt, o_rd_we;
  logic [31:0] o_pc, o_imm;
  logic [3:0]  o_class;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rs1, o_rs2, o_rd;

  always #5 i_clk = ~i_clk;

  rv_decode dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .i_pc(i_pc), .i_instruction(i_instruction), .o_ready(o_ready), .i_stall(i_stall),
    .o_valid(o_valid), .o_pc(o_pc), .o_class(o_class), .o_funct3(o_funct3), .o_alt(o_alt),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_rd_we(o_rd_we), .o_imm(o_imm)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference decode (arithmetic on fields) ----------------
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'd1 << bits;
    return v[bits-1] ? v - m : v;
  endfunction

  // Returns {pc, class, funct3, alt, rs1, rs2, rd, rd_we, imm} (88 bits).
  function automatic logic [87:0] ref_dec(input logic [31:0] pc, input logic [31:0] w);
    int op, f3, f7, rd, cls;
    logic [31:0] imm;
    logic alt, bad, we;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]); rd = int'(w[11:7]);
    alt = 0; bad = 0; imm = 0; cls = 15;
    case (op)
      'h37: begin cls = 0;  imm = w & 32'hFFFFF000; end
      'h17: begin cls = 1;  imm = w & 32'hFFFFF000; end
      'h6F: begin cls = 2;  imm = sx(w[31]*(1<<20) + w[19:12]*(1<<12) + w[20]*(1<<11) + w[30:21]*2, 21); end
      'h67: begin cls = 3;  imm = sx(32'(w[31:20]), 12); bad = (f3 != 0); end
      'h63: begin cls = 4;  imm = sx(w[31]*4096 + w[7]*2048 + w[30:25]*32 + w[11:8]*2, 13);
                  bad = (f3 == 2 || f3 == 3); end
      'h03: begin cls = 5;  imm = sx(32'(w[31:20]), 12); bad = (f3 == 3 || f3 >= 6); end
      'h23: begin cls = 6;  imm = sx(w[31:25]*32 + 32'(w[11:7]), 12); bad = (f3 > 2); end
      'h13: begin cls = 7;  imm = sx(32'(w[31:20]), 12);
                  if (f3 == 1) begin alt = w[30]; bad = (f7 != 0); end
                  if (f3 == 5) begin alt = w[30]; bad = !(f7 == 0 || f7 == 'h20); end end
      'h33: begin
              if (f7 == 0) cls = 8;
              else if (f7 == 'h20) begin cls = 8; alt = 1; bad = !(f3 == 0 || f3 == 5); end
`ifdef EXTENSION_M_EN
              else if (f7 == 1) cls = 11;
`endif
              else bad = 1;
            end
      'h0F: begin cls = 9;  imm = sx(32'(w[31:20]), 12); end
      'h73: begin cls = 10; imm = sx(32'(w[31:20]), 12); end
      default: bad = 1;
    endcase
    if (bad) begin cls = 15; imm = 0; alt = 0; end
    we = !(cls == 15 || cls == 4 || cls == 6 || cls == 9 || rd == 0);
    return {pc, 4'(cls), w[14:12], alt, w[19:15], w[24:20], w[11:7], we, imm};
  endfunction

  // ---------------- occupancy model: queue of held words ----------------
  typedef struct { logic [31:0] pc; logic [31:0] ins; } item_t;
  item_t q[$];
  logic  m_ready = 1'b1;

  function automatic logic [87:0] dut_out();
    return {o_pc, o_class, o_funct3, o_alt, o_rs1, o_rs2, o_rd, o_rd_we, o_imm};
  endfunction

  task automatic cycle(input logic rst, input logic fl, input logic vld,
                       input logic [31:0] pc, input logic [31:0] ins, input logic stl);
    item_t it;
    i_reset = rst; i_flush = fl; i_valid = vld; i_pc = pc; i_instruction = ins; i_stall = stl;
    @(posedge i_clk);
    if (rst || fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && !stl) void'(q.pop_front());
      if (vld && m_ready) begin it.pc = pc; it.ins = ins; q.push_back(it); end
    end
    m_ready = (q.size() < 2);
    #1;
    chk("valid", o_valid, q.size() > 0);
    chk("ready", o_ready, m_ready);
    if (q.size() > 0) chk("decode", dut_out(), ref_dec(q[0].pc, q[0].ins));
  endtask

  task automatic idle(input logic stl);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, stl);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic        alt;
    logic        we;
    logic [31:0] imm;
  } vec_t;
  vec_t tv[13];

  logic [31:0] r_ins;
  int          sel;
  logic [6:0]  ops[11];
  logic [6:0]  f7s[4];

  initial begin
    tv[0]  = '{32'h00500093, 32'h0000_0000, 4'd7,  1'b0, 1'b1, 32'd5};        // addi x1,x0,5
    tv[1]  = '{32'hFE000EE3, 32'h0000_0100, 4'd4,  1'b0, 1'b0, 32'hFFFFFFFC}; // beq -4
`ifdef EXTENSION_M_EN
    tv[2]  = '{32'h022081B3, 32'h0000_0104, 4'd11, 1'b0, 1'b1, 32'd0};        // mul x3,x1,x2
`else
    tv[2]  = '{32'h022081B3, 32'h0000_0104, 4'd15, 1'b0, 1'b0, 32'd0};
`endif
    tv[3]  = '{32'h00000013, 32'h0000_0108, 4'd7,  1'b0, 1'b0, 32'd0};        // nop
    tv[4]  = '{32'h00000000, 32'h0000_010C, 4'd15, 1'b0, 1'b0, 32'd0};
    tv[5]  = '{32'h123450B7, 32'h0000_0110, 4'd0,  1'b0, 1'b1, 32'h12345000}; // lui
    tv[6]  = '{32'h000000EF, 32'h0000_0114, 4'd2,  1'b0, 1'b1, 32'd0};        // jal x1,0
    tv[7]  = '{32'h0020A423, 32'h0000_0118, 4'd6,  1'b0, 1'b0, 32'd8};        // sw x2,8(x1)
    tv[8]  = '{32'h0000B083, 32'h0000_011C, 4'd15, 1'b0, 1'b0, 32'd0};        // load f3=3
    tv[9]  = '{32'h4030D093, 32'h0000_0120, 4'd7,  1'b1, 1'b1, 32'h00000403}; // srai
    tv[10] = '{32'h402081B3, 32'h0000_0124, 4'd8,  1'b1, 1'b1, 32'd0};        // sub
    tv[11] = '{32'h402091B3, 32'h0000_0128, 4'd15, 1'b0, 1'b0, 32'd0};        // f7=0x20 f3=1
    tv[12] = '{32'h000090E7, 32'h0000_012C, 4'd15, 1'b0, 1'b0, 32'd0};        // jalr f3=1

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset_outs", dut_out(), {32'd0, 4'd15, 3'd0, 1'b0, 15'd0, 1'b0, 32'd0});

    // Table: one word per cycle with an idle cycle after, no stall.
    foreach (tv[i]) begin
      cycle(1'b0, 1'b0, 1'b1, tv[i].pc, tv[i].ins, 1'b0);
      chk($sformatf("tv%0d", i), {o_valid, o_pc, o_class, o_alt, o_rd_we, o_imm},
          {1'b1, tv[i].pc, tv[i].cls, tv[i].alt, tv[i].we, tv[i].imm});
      idle(1'b0);
    end
    // First table entry fields, addi x1,x0,5.
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 32'h00500093, 1'b0);
    chk("addi_regs", {o_rd, o_rs1}, {5'd1, 5'd0});
    cycle(1'b0, 1'b0, 1'b1, 32'h204, 32'h022081B3, 1'b0);
    chk("mul_regs", {o_rd, o_rs1, o_rs2}, {5'd3, 5'd1, 5'd2});
    idle(1'b0);

    // Stall with four back-to-back offers: two accepted, then drained in order.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 32'h300 + 32'(4*k), 32'h00100093 + (32'(k) << 20), 1'b1);
    chk("stall_ready", o_ready, 1'b0);
    chk("stall_pc", {o_valid, o_pc}, {1'b1, 32'h300});
    idle(1'b0);
    chk("drain1", {o_valid, o_pc, o_ready}, {1'b1, 32'h304, 1'b1});
    idle(1'b0);
    chk("drain2", o_valid, 1'b0);

    // OR and SK full, flush with a simultaneous offer.
    cycle(1'b0, 1'b0, 1'b1, 32'h400, 32'h00000013, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h404, 32'h00000013, 1'b1);
    chk("full_ready", o_ready, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h408, 32'h00000013, 1'b1);
    chk("flush", {o_valid, o_ready}, {1'b0, 1'b1});
    idle(1'b0);
    chk("flush_empty", o_valid, 1'b0);

    // Reset beats flush and an offer.
    cycle(1'b0, 1'b0, 1'b1, 32'h500, 32'h00500093, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h504, 32'h00500093, 1'b0);
    chk("reset_over_flush", {o_valid, o_ready, o_class, o_pc}, {1'b0, 1'b1, 4'd15, 32'd0});

    // Random traffic.
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h7F};
    for (int n = 0; n < 1500; n++) begin
      r_ins = $urandom;
      sel = int'($urandom_range(0, 12));
      if (sel < 11) r_ins[6:0] = ops[sel];
      if ($urandom_range(0, 1) == 1) r_ins[31:25] = f7s[$urandom_range(0, 3)];
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 33) == 0,
            $urandom_range(0, 9) < 7, $urandom, r_ins, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
